// File: rtl/cic_pkg.sv
// cic_pkg: shared definitions for the channelizer CIC datapath.
//   CIC_DW   - native sample width on the 48-bit P path
//   clog2    - elaboration-time ceil(log2(v))
//   sample_t - signed CIC_DW-bit sample
package cic_pkg;

  localparam int CIC_DW = 48;

  typedef logic signed [CIC_DW-1:0] sample_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/cic_comb_m256_if.sv
// cic_comb_m256_if: AXI-Stream bundle (tvalid/tdata/tready).
//   master - drives tvalid/tdata, samples tready
//   slave  - samples tvalid/tdata, drives tready
interface cic_comb_m256_if #(
  parameter int DW = 48
);
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          tready;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/cic_comb_out_fifo.sv
// cic_comb_out_fifo: synchronous FIFO with a registered AXI-Stream output.
//   clk, sync_reset_n - clock, synchronous active-low reset
//   i_push, i_data    - write port (caller guarantees no push when full
//                       unless a load to the output register happens too)
//   o_count           - words held in storage, not counting the output reg
//   m_axis            - AXI-Stream master side
// Data always goes through storage before the output register, so a word
// pushed at edge N is presented after edge N+1.
module cic_comb_out_fifo
  import cic_pkg::*;
#(
  parameter int DW    = CIC_DW,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  sync_reset_n,
  input  logic                  i_push,
  input  logic [DW-1:0]         i_data,
  output logic [clog2(DEPTH):0] o_count,
  cic_comb_m256_if.master       m_axis
);

  localparam int PW = clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0]   r_cnt;
  logic          r_ovld;
  logic [DW-1:0] r_odata;
  logic          w_load;

  // refill the output register whenever it is empty or being consumed
  assign w_load = (r_cnt != '0) && (!r_ovld || m_axis.tready);

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_ovld  <= 1'b0;
      r_odata <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (w_load) begin
        r_rp    <= r_rp + 1'b1;
        r_odata <= r_mem[r_rp];
        r_ovld  <= 1'b1;
      end else if (m_axis.tready) begin
        r_ovld  <= 1'b0;
      end
      unique case ({i_push, w_load})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // storage carries no reset; r_cnt alone decides what is valid
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_data;
  end

  assign o_count       = r_cnt;
  assign m_axis.tvalid = r_ovld;
  assign m_axis.tdata  = r_odata;

endmodule

// File: rtl/cic_comb_m256.sv
// cic_comb_m256: CIC comb stage, y[n] = x[n] - x[n-M] mod 2^DW.
//   clk, sync_reset_n - clock, synchronous active-low reset
//   s_axis            - input samples (AXI-Stream slave)
//   m_axis            - comb output (AXI-Stream master)
// Pipeline: stage 0 reads-then-writes the delay line on accept, stage 1
// forms the difference, then the sample enters the output FIFO. The
// pipeline never stalls; admission is throttled so the FIFO cannot
// overflow. The first M outputs are raw inputs so unwritten RAM is never
// seen, including after a mid-stream reset.
module cic_comb_m256
  import cic_pkg::*;
#(
  parameter int DW         = CIC_DW,
  parameter int M          = 256,
  parameter int AW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           sync_reset_n,
  cic_comb_m256_if.slave  s_axis,
  cic_comb_m256_if.master m_axis
);

  localparam int STAGES = 1;
  localparam int CW     = clog2(FIFO_DEPTH) + 1;
  localparam logic [AW:0] FILL_MAX = (AW+1)'(M);
  localparam logic [CW:0] OCC_MAX  = (CW+1)'(FIFO_DEPTH - 1);

  if (M < 2 || M > 1024 || (M & (M - 1)) != 0 || AW != clog2(M)) begin : g_bad_m
    $fatal(1, "cic_comb_m256: M must be a power of 2 in 2..1024 and AW == log2(M)");
  end
  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo
    $fatal(1, "cic_comb_m256: FIFO_DEPTH must be a power of 2, at least 4");
  end

  logic [DW-1:0]     r_ram [M];
  logic [STAGES:0]   r_vld_pipe;
  logic              r_run;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW:0]       r_fill_cnt;
  logic [DW-1:0]     r_x0, r_old, r_diff;
  logic              r_prm0;
  logic              w_acc, w_primed;
  logic [CW-1:0]     w_fifo_cnt;
  logic [CW:0]       w_occ;

  assign w_primed = (r_fill_cnt == FILL_MAX);

  // every valid pipeline stage already owns a FIFO slot
  assign w_occ = {1'b0, w_fifo_cnt}
               + {{CW{1'b0}}, r_vld_pipe[0]}
               + {{CW{1'b0}}, r_vld_pipe[1]};

  // r_run holds tready low through reset and for the release edge
  assign s_axis.tready = r_run && (w_occ <= OCC_MAX);
  assign w_acc         = s_axis.tvalid && s_axis.tready;

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      r_run      <= 1'b0;
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_vld_pipe <= '0;
      r_x0       <= '0;
      r_prm0     <= 1'b0;
      r_diff     <= '0;
    end else begin
      r_run      <= 1'b1;
      r_vld_pipe <= {r_vld_pipe[STAGES-1:0], w_acc};
      if (w_acc) begin
        r_x0     <= s_axis.tdata;
        r_prm0   <= w_primed;
        r_wr_ptr <= r_wr_ptr + 1'b1;  // AW == log2(M): wraps M-1 -> 0
        if (!w_primed) r_fill_cnt <= r_fill_cnt + 1'b1;
      end
      // modular subtract; overflow wraps like the integrators upstream
      if (r_vld_pipe[0]) r_diff <= r_x0 - (r_prm0 ? r_old : '0);
    end
  end

  // read-first delay line, one BRAM at M=256; contents are never reset
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_old             <= r_ram[r_wr_ptr];
      r_ram[r_wr_ptr]   <= s_axis.tdata;
    end
  end

  cic_comb_out_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .sync_reset_n (sync_reset_n),
    .i_push       (r_vld_pipe[1]),
    .i_data       (r_diff),
    .o_count      (w_fifo_cnt),
    .m_axis       (m_axis)
  );

endmodule

// File: tb/tb_cic_comb_m256.sv
module tb_cic_comb_m256;
  import cic_pkg::*;

  localparam int DW = CIC_DW;

  logic clk = 1'b0;
  logic sync_reset_n = 1'b0;
  always #5 clk = ~clk;

  cic_comb_m256_if #(.DW(DW)) a_s (), a_m (), b_s (), b_m ();

  cic_comb_m256 #(.DW(DW), .M(256), .AW(8), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .sync_reset_n(sync_reset_n), .s_axis(a_s), .m_axis(a_m));

  cic_comb_m256 #(.DW(DW), .M(4), .AW(2), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .sync_reset_n(sync_reset_n), .s_axis(b_s), .m_axis(b_m));

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int first_out = -1, last_out = -1, first_acc = -1, last_acc = -1;
  int hold_viol = 0, fifo_max = 0;
  bit bp_mode = 1'b0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] qa [$];
  logic [DW-1:0] qb [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // downstream ready: always 1, or a coin flip during the backpressure run
  always begin
    @(posedge clk);
    #1 a_m.tready = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (a_m.tvalid === 1'b1 && a_m.tready === 1'b1) begin
      qa.push_back(a_m.tdata);
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    if (prev_stall && (a_m.tvalid !== 1'b1 || a_m.tdata !== prev_data)) hold_viol++;
    prev_stall = sync_reset_n && a_m.tvalid === 1'b1 && a_m.tready !== 1'b1;
    prev_data  = a_m.tdata;
    if (int'(u_a.w_fifo_cnt) > fifo_max) fifo_max = int'(u_a.w_fifo_cnt);
    if (b_m.tvalid === 1'b1 && b_m.tready === 1'b1) qb.push_back(b_m.tdata);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // called at posedge+1; returns at posedge+1 after the handshake edge
  task automatic send_a(input logic [DW-1:0] x);
    int g;
    g = 0;
    a_s.tvalid = 1'b1;
    a_s.tdata  = x;
    @(negedge clk);
    while (a_s.tready !== 1'b1) begin
      g++;
      if (g > 2000) begin
        $display("FAIL send_a: s_axis_tready stuck low got 0 expected 1");
        $fatal(1, "send_a timeout");
      end
      @(negedge clk);
    end
    if (first_acc < 0) first_acc = cyc + 1;
    last_acc = cyc + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic [DW-1:0] x);
    int g;
    g = 0;
    b_s.tvalid = 1'b1;
    b_s.tdata  = x;
    @(negedge clk);
    while (b_s.tready !== 1'b1) begin
      g++;
      if (g > 2000) begin
        $display("FAIL send_b: s_axis_tready stuck low got 0 expected 1");
        $fatal(1, "send_b timeout");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    a_s.tvalid = 1'b0;
    b_s.tvalid = 1'b0;
    sync_reset_n = 1'b0;
    repeat (n) @(posedge clk);
    #1 sync_reset_n = 1'b1;
    @(posedge clk);
    #1;
    qa.delete();
    qb.delete();
    first_out = -1; last_out = -1; first_acc = -1; last_acc = -1;
  endtask

  task automatic wait_a(input string tag, input int n);
    int g;
    g = 0;
    while (qa.size() < n && g < 20000) begin
      @(negedge clk);
      g++;
    end
    repeat (10) @(negedge clk);
    chk({tag, "_count"}, 64'(qa.size()), 64'(n));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_b(input string tag, input int n);
    int g;
    g = 0;
    while (qb.size() < n && g < 2000) begin
      @(negedge clk);
      g++;
    end
    repeat (10) @(negedge clk);
    chk({tag, "_count"}, 64'(qb.size()), 64'(n));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] e;
    a_s.tvalid = 1'b0; a_s.tdata = '0;
    b_s.tvalid = 1'b0; b_s.tdata = '0;
    b_m.tready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 64'(a_m.tvalid), 64'd0);
    chk("rst_m_tdata",  64'(a_m.tdata),  64'd0);
    chk("rst_s_tready", 64'(a_s.tready), 64'd0);
    chk("rst_b_s_tready", 64'(b_s.tready), 64'd0);
    @(posedge clk);
    #1 sync_reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_s_tready", 64'(a_s.tready), 64'd1);
    chk("rel_m_tvalid", 64'(a_m.tvalid), 64'd0);
    @(posedge clk);
    #1;

    // impulse: 5 then 600 zeros
    for (int n = 0; n < 601; n++) send_a(n == 0 ? 48'd5 : 48'd0);
    a_s.tvalid = 1'b0;
    wait_a("imp", 601);
    chk("imp_latency", 64'(first_out - first_acc), 64'd3);
    chk("imp_in_rate", 64'(last_acc - first_acc), 64'd600);
    chk("imp_out_rate", 64'(last_out - first_out), 64'd600);
    for (int n = 0; n < 601; n++) begin
      e = (n == 0) ? 48'd5 : (n == 256) ? 48'hFFFF_FFFF_FFFB : 48'd0;
      chk($sformatf("imp[%0d]", n), 64'(qa[n]), 64'(e));
    end

    // step: ones
    do_reset(2);
    for (int n = 0; n < 600; n++) send_a(48'd1);
    a_s.tvalid = 1'b0;
    wait_a("step", 600);
    for (int n = 0; n < 600; n++)
      chk($sformatf("step[%0d]", n), 64'(qa[n]), (n < 256) ? 64'd1 : 64'd0);

    // wrap: max positive, then most negative 256 samples later
    do_reset(2);
    for (int n = 0; n < 260; n++)
      send_a(n == 0 ? 48'h7FFF_FFFF_FFFF : n == 256 ? 48'h8000_0000_0000 : 48'd0);
    a_s.tvalid = 1'b0;
    wait_a("wrap", 260);
    for (int n = 0; n < 260; n++) begin
      e = (n == 0) ? 48'h7FFF_FFFF_FFFF : (n == 256) ? 48'h0000_0000_0001 : 48'd0;
      chk($sformatf("wrap[%0d]", n), 64'(qa[n]), 64'(e));
    end

    // backpressure: ramp with random downstream ready
    do_reset(2);
    bp_mode = 1'b1;
    fifo_max = 0;
    hold_viol = 0;
    for (int n = 0; n < 2000; n++) send_a(48'(n));
    a_s.tvalid = 1'b0;
    wait_a("bp", 2000);
    bp_mode = 1'b0;
    for (int n = 0; n < 2000; n++)
      chk($sformatf("bp[%0d]", n), 64'(qa[n]), (n < 256) ? 64'(n) : 64'd256);
    chk("bp_fifo_le_depth", 64'(fifo_max <= 4), 64'd1);
    chk("bp_axi_hold", 64'(hold_viol), 64'd0);
    repeat (3) @(posedge clk);
    #1;

    // mid-stream reset: 300 x 7, one reset cycle, 300 x 7 again
    do_reset(2);
    for (int n = 0; n < 300; n++) send_a(48'd7);
    a_s.tvalid = 1'b0;
    sync_reset_n = 1'b0;
    @(posedge clk);
    #1 sync_reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_m_tvalid", 64'(a_m.tvalid), 64'd0);
    chk("mid_rst_s_tready", 64'(a_s.tready), 64'd0);
    @(posedge clk);
    #1;
    qa.delete();
    for (int n = 0; n < 300; n++) send_a(48'd7);
    a_s.tvalid = 1'b0;
    wait_a("mid", 300);
    for (int n = 0; n < 300; n++)
      chk($sformatf("mid[%0d]", n), 64'(qa[n]), (n < 256) ? 64'd7 : 64'd0);

    // small M = 4: ramp 1..12 -> 1,2,3,4,4,...
    do_reset(2);
    for (int v = 1; v <= 12; v++) send_b(48'(v));
    b_s.tvalid = 1'b0;
    wait_b("m4", 12);
    for (int n = 0; n < 12; n++)
      chk($sformatf("m4[%0d]", n), 64'(qb[n]), (n < 4) ? 64'(n + 1) : 64'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
